// File: rtl/data_bus_arbiter.sv
// Two-master data-memory arbiter (fetch = m0, LSU = m1) with in-order response routing.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; otherwise m1 has fixed priority over m0.
module data_bus_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    input  logic [DATA_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    input  logic [DATA_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [DATA_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,

    output logic                  err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic                       lock_q, lock_d;
    logic                       lock_sel_q, lock_sel_d;
    logic                       err_q, err_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                       last_q, last_d;
`endif

    logic full;
    logic empty;
    logic sel;
    logic accept;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);

    // A pending (locked) selection always wins so the downstream address phase stays stable.
    always_comb begin
        if (lock_q) begin
            sel = lock_sel_q;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (m0_req_i && m1_req_i) begin
            sel = ~last_q;
        end
`endif
        else begin
            sel = m1_req_i;
        end
    end

    assign data_req_o   = rst_ni & (m0_req_i | m1_req_i) & ~full;
    assign data_addr_o  = rst_ni ? (sel ? m1_addr_i  : m0_addr_i)  : '0;
    assign data_we_o    = rst_ni & (sel ? m1_we_i : m0_we_i);
    assign data_wdata_o = rst_ni ? (sel ? m1_wdata_i : m0_wdata_i) : '0;

    assign accept   = data_req_o & data_gnt_i;
    assign m0_gnt_o = accept & ~sel;
    assign m1_gnt_o = accept &  sel;

    assign head        = fifo_q[rd_ptr_q];
    assign pop         = data_rvalid_i & ~empty;
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop &  head;

    assign m0_rdata_o = data_rdata_i;
    assign m1_rdata_o = data_rdata_i;
    assign err_o      = err_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fifo_d   = fifo_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (accept) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // Lock is armed by a refused request and released by the grant that completes it.
    always_comb begin
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        if (data_req_o) begin
            lock_d     = ~data_gnt_i;
            lock_sel_d = sel;
        end
    end

    assign err_d = err_q | (data_rvalid_i & empty);

`ifdef ARB_ROUND_ROBIN_EN
    assign last_d = accept ? sel : last_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_q     <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_q     <= fifo_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            err_q      <= err_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios followed by random traffic,
// compared against a queue-based model of outstanding transactions.
module tb_data_bus_arbiter;

    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          m0_req_i, m1_req_i;
    logic          m0_gnt_o, m1_gnt_o;
    logic          m0_rvalid_o, m1_rvalid_o;
    logic [DW-1:0] m0_addr_i, m1_addr_i;
    logic          m0_we_i, m1_we_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          data_req_o, data_gnt_i, data_rvalid_i;
    logic [DW-1:0] data_addr_o;
    logic          data_we_o;
    logic [DW-1:0] data_wdata_o;
    logic [DW-1:0] data_rdata_i;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: IDs of granted-but-unanswered transactions, oldest first.
    int unsigned mq[$];
    bit lock_m, lock_id_m, last_m, err_m;
    bit e_req, e_sel, e_g0, e_g1, e_rv0, e_rv1;

    // Master-side bookkeeping for random traffic.
    bit p0, p1;

    always #5 clk_i = ~clk_i;

    data_bus_arbiter #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_wdata_o(data_wdata_o),
        .data_rdata_i(data_rdata_i), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit r0, input bit r1, input bit g,
                                 input bit rv, input logic [DW-1:0] rd);
        @(negedge clk_i);
        rst_ni        = ~rst;
        m0_req_i      = r0;
        m1_req_i      = r1;
        data_gnt_i    = g;
        data_rvalid_i = rv;
        data_rdata_i  = rd;
        #1;
    endtask

    task automatic checkOutput(input bit rst);
        logic [DW-1:0] e_addr, e_wdata;
        bit            e_we;
        if (rst) begin
            mq.delete();
            lock_m = 0; lock_id_m = 0; last_m = 0; err_m = 0;
            e_req = 0; e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0;
            e_addr = '0; e_wdata = '0; e_we = 0;
        end else begin
            e_req = (m0_req_i || m1_req_i) && (mq.size() < MAXO);
            if (lock_m)
                e_sel = lock_id_m;
`ifdef ARB_ROUND_ROBIN_EN
            else if (m0_req_i && m1_req_i)
                e_sel = !last_m;
`endif
            else
                e_sel = m1_req_i;
            e_addr  = e_sel ? m1_addr_i  : m0_addr_i;
            e_wdata = e_sel ? m1_wdata_i : m0_wdata_i;
            e_we    = e_sel ? m1_we_i    : m0_we_i;
            e_g0    = data_gnt_i && e_req && !e_sel;
            e_g1    = data_gnt_i && e_req && e_sel;
            e_rv0   = data_rvalid_i && mq.size() > 0 && mq[0] == 0;
            e_rv1   = data_rvalid_i && mq.size() > 0 && mq[0] == 1;
        end
        chk("data_req", DW'(data_req_o), DW'(e_req));
        chk("data_addr", data_addr_o, e_addr);
        chk("data_we", DW'(data_we_o), DW'(e_we));
        chk("data_wdata", data_wdata_o, e_wdata);
        chk("m0_gnt", DW'(m0_gnt_o), DW'(e_g0));
        chk("m1_gnt", DW'(m1_gnt_o), DW'(e_g1));
        chk("m0_rvalid", DW'(m0_rvalid_o), DW'(e_rv0));
        chk("m1_rvalid", DW'(m1_rvalid_o), DW'(e_rv1));
        chk("m0_rdata", m0_rdata_o, data_rdata_i);
        chk("m1_rdata", m1_rdata_o, data_rdata_i);
        chk("err", DW'(err_o), DW'(err_m));
        if (!rst) begin
            if (data_rvalid_i) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else err_m = 1;
            end
            if (e_req) begin
                if (data_gnt_i) begin
                    mq.push_back(e_sel);
                    last_m = e_sel;
                    lock_m = 0;
                end else begin
                    lock_m    = 1;
                    lock_id_m = e_sel;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit r0, input bit r1, input bit g,
                        input bit rv, input logic [DW-1:0] rd);
        applyStimulus(rst, r0, r1, g, rv, rd);
        checkOutput(rst);
    endtask

    initial begin
        rst_ni = 0; m0_req_i = 0; m1_req_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
        data_rdata_i = '0; m0_we_i = 0; m1_we_i = 0;
        m0_addr_i = '0; m1_addr_i = '0; m0_wdata_i = '0; m1_wdata_i = '0;

        // Reset, including requests asserted while in reset.
        step(1, 0, 0, 0, 0, 32'h0);
        step(1, 1, 1, 1, 0, 32'h1234_5678);

        // Single m0 read, response one cycle later.
        m0_addr_i = 32'h100;
        step(0, 1, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 0, 32'h0);

        // Both request with gnt every cycle: m1 first, then m0; responses in order.
        m0_addr_i = 32'h200; m1_addr_i = 32'h300; m1_we_i = 1; m1_wdata_i = 32'hA5A5_0001;
        step(0, 1, 1, 1, 0, 32'h0);
        step(0, 1, 0, 1, 1, 32'h1111_1111);
        step(0, 0, 0, 0, 1, 32'h2222_2222);
        m1_we_i = 0;

        // Lock: m0 refused three cycles, m1 joins, m0 keeps the bus until granted.
        m0_addr_i = 32'h400; m1_addr_i = 32'h500;
        step(0, 1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 32'h0);
        step(0, 1, 1, 0, 0, 32'h0);
        step(0, 1, 1, 1, 0, 32'h0);
        step(0, 0, 1, 1, 1, 32'h3333_3333);
        step(0, 0, 0, 0, 1, 32'h4444_4444);

        // Full: two grants, then stall; a pop frees a slot only for the following cycle.
        m1_addr_i = 32'h600;
        step(0, 0, 1, 1, 0, 32'h0);
        m1_addr_i = 32'h604;
        step(0, 0, 1, 1, 0, 32'h0);
        m1_addr_i = 32'h608;
        step(0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 1, 1, 1, 32'h5555_5555);
        step(0, 0, 1, 1, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h6666_6666);
        step(0, 0, 0, 0, 1, 32'h7777_7777);

        // Spurious response sets a sticky error.
        step(0, 0, 0, 0, 1, 32'h8888_8888);
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);

        // Async reset mid-burst drops the outstanding ID; the late response is then an error.
        m0_addr_i = 32'h700;
        step(0, 1, 0, 1, 0, 32'h0);
        step(1, 1, 1, 1, 0, 32'h0);
        step(0, 0, 0, 0, 1, 32'h9999_9999);
        step(0, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);

        // Random traffic; masters hold their address phase until granted.
        p0 = 0; p1 = 0;
        for (int i = 0; i < 400; i++) begin
            bit g, rv;
            if (!p0 && $urandom_range(0, 2) == 0) begin
                p0 = 1; m0_addr_i = $urandom; m0_we_i = 1'($urandom_range(0, 1)); m0_wdata_i = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1 = 1; m1_addr_i = $urandom; m1_we_i = 1'($urandom_range(0, 1)); m1_wdata_i = $urandom;
            end
            g  = ($urandom_range(0, 3) != 0);
            rv = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            step(0, p0, p1, g, rv, $urandom);
            if (e_g0) p0 = 0;
            if (e_g1) p1 = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
